pin_motion_integrator: RTL and testbench

PIN_MOTION_INTEGRATOR -- requirements
Module: pin_motion_integrator

---
 rtl/pin_motion_if.sv | 31 +++
 rtl/pin_motion_integrator.sv | 210 +++++++++++++++++++++
 tb/tb_pin_motion_integrator.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pin_motion_if.sv
// Bus between the pin motion integrator and its surroundings: step/rack
// commands, status flags, the collision request/result handshake and pin state.
interface pin_motion_if;
    logic              step_in;
    logic              rack_in;
    logic              busy_out;
    logic              step_done_out;
    logic              timeout_out;
    logic              coll_valid_out;
    logic              coll_done_in;
    logic [9:0][15:0]  coll_vx_in;
    logic [9:0][15:0]  coll_vy_in;
    logic [9:0]        coll_hit_in;
    logic [9:0][15:0]  pins_x_out;
    logic [9:0][15:0]  pins_y_out;
    logic [9:0][15:0]  pins_vx_out;
    logic [9:0][15:0]  pins_vy_out;
    logic [9:0]        pins_hit_out;

    modport master (
        input  step_in, rack_in, coll_done_in, coll_vx_in, coll_vy_in, coll_hit_in,
        output busy_out, step_done_out, timeout_out, coll_valid_out,
               pins_x_out, pins_y_out, pins_vx_out, pins_vy_out, pins_hit_out
    );

    modport slave (
        output step_in, rack_in, coll_done_in, coll_vx_in, coll_vy_in, coll_hit_in,
        input  busy_out, step_done_out, timeout_out, coll_valid_out,
               pins_x_out, pins_y_out, pins_vx_out, pins_vy_out, pins_hit_out
    );
endinterface

// File: rtl/pin_motion_integrator.sv
// Ten-pin physics stepper: requests a collision result, latches struck-pin velocities,
// then integrates positions one pin per cycle. Optional velocity decay: PIN_FRICTION_EN.
module pin_motion_integrator #(
    parameter int POS_SHIFT      = 2,
    parameter int FRICTION_SHIFT = 4,
    parameter int TIMEOUT        = 255
) (
    input  logic          clk_in,
    input  logic          rst_in,
    pin_motion_if.master  bus
);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [3:0]       LAST_PIN  = 4'd9;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_INTEG = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [CNT_W-1:0]  wait_cnt_r;
    logic [3:0]        pin_idx_r;
    logic              wait_expired_s;
    logic              coll_valid_s;
    logic              busy_s;
    logic              step_done_s;
    logic              coll_valid_r;
    logic              busy_r;
    logic              step_done_r;
    logic              timeout_r;
    logic [9:0][15:0]  pins_x_r;
    logic [9:0][15:0]  pins_y_r;
    logic [9:0][15:0]  pins_vx_r;
    logic [9:0][15:0]  pins_vy_r;
    logic [9:0]        pins_hit_r;

    function automatic logic [15:0] rack_x(input logic [3:0] idx);
        case (idx)
            4'd0:    return 16'd512;
            4'd1:    return 16'd452;
            4'd2:    return 16'd572;
            4'd3:    return 16'd392;
            4'd4:    return 16'd512;
            4'd5:    return 16'd632;
            4'd6:    return 16'd332;
            4'd7:    return 16'd452;
            4'd8:    return 16'd572;
            4'd9:    return 16'd692;
            default: return 16'd0;
        endcase
    endfunction

    function automatic logic [15:0] rack_y(input logic [3:0] idx);
        case (idx)
            4'd0:                   return 16'd300;
            4'd1, 4'd2:             return 16'd404;
            4'd3, 4'd4, 4'd5:       return 16'd508;
            4'd6, 4'd7, 4'd8, 4'd9: return 16'd612;
            default:                return 16'd0;
        endcase
    endfunction

    // Position plus scaled velocity, clamped to the unsigned 16-bit field.
    function automatic logic [15:0] sat_pos(input logic [15:0] pos, input logic [15:0] vel);
        logic signed [17:0] pos_ext;
        logic signed [17:0] vel_ext;
        logic signed [17:0] sum;
        pos_ext = $signed({2'b00, pos});
        vel_ext = $signed({{2{vel[15]}}, vel}) >>> POS_SHIFT;
        sum     = pos_ext + vel_ext;
        if (sum[17]) begin
            return 16'd0;
        end else if (sum[16]) begin
            return 16'hFFFF;
        end else begin
            return sum[15:0];
        end
    endfunction

`ifdef PIN_FRICTION_EN
    function automatic logic [15:0] decay(input logic [15:0] vel);
        logic signed [16:0] v_ext;
        logic [16:0]        mag;
        v_ext = $signed({vel[15], vel});
        mag   = vel[15] ? 17'(-v_ext) : 17'(v_ext);
        if (mag < (17'd1 << FRICTION_SHIFT)) begin
            return 16'd0;
        end else begin
            return 16'(v_ext - (v_ext >>> FRICTION_SHIFT));
        end
    endfunction
`endif

    assign wait_expired_s = (wait_cnt_r == TIMEOUT_C);

    // State register
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; rack aborts any step in progress
    always_comb begin
        state_next_s = state_r;
        if (bus.rack_in) begin
            state_next_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE:  state_next_s = bus.step_in ? S_REQ : S_IDLE;
                S_REQ:   state_next_s = S_WAIT;
                S_WAIT:  state_next_s = (bus.coll_done_in || wait_expired_s) ? S_INTEG : S_WAIT;
                S_INTEG: state_next_s = (pin_idx_r == LAST_PIN) ? S_DONE : S_INTEG;
                S_DONE:  state_next_s = S_IDLE;
                default: state_next_s = S_IDLE;
            endcase
        end
    end

    // Output decode from the upcoming state so the registered flags line up with it
    always_comb begin
        coll_valid_s = (state_next_s == S_REQ);
        busy_s       = (state_next_s != S_IDLE);
        step_done_s  = (state_next_s == S_DONE);
    end

    // Registered control outputs
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            coll_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            step_done_r  <= 1'b0;
        end else begin
            coll_valid_r <= coll_valid_s;
            busy_r       <= busy_s;
            step_done_r  <= step_done_s;
        end
    end

    // Pin state, wait counter, pin index and the sticky timeout flag
    always_ff @(posedge clk_in) begin
        if (rst_in || bus.rack_in) begin
            for (int i = 0; i < 10; i++) begin
                pins_x_r[i]  <= rack_x(4'(i));
                pins_y_r[i]  <= rack_y(4'(i));
                pins_vx_r[i] <= 16'd0;
                pins_vy_r[i] <= 16'd0;
            end
            pins_hit_r <= 10'd0;
            wait_cnt_r <= '0;
            pin_idx_r  <= 4'd0;
            timeout_r  <= rst_in ? 1'b0 : timeout_r;
        end else begin
            case (state_r)
                S_REQ: begin
                    wait_cnt_r <= '0;
                end
                S_WAIT: begin
                    if (bus.coll_done_in) begin
                        for (int i = 0; i < 10; i++) begin
                            if (bus.coll_hit_in[i]) begin
                                pins_vx_r[i]  <= bus.coll_vx_in[i];
                                pins_vy_r[i]  <= bus.coll_vy_in[i];
                                pins_hit_r[i] <= 1'b1;
                            end
                        end
                        wait_cnt_r <= '0;
                    end else if (wait_expired_s) begin
                        timeout_r  <= 1'b1;
                        wait_cnt_r <= '0;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 1'b1;
                    end
                end
                S_INTEG: begin
                    pins_x_r[pin_idx_r] <= sat_pos(pins_x_r[pin_idx_r], pins_vx_r[pin_idx_r]);
                    pins_y_r[pin_idx_r] <= sat_pos(pins_y_r[pin_idx_r], pins_vy_r[pin_idx_r]);
`ifdef PIN_FRICTION_EN
                    pins_vx_r[pin_idx_r] <= decay(pins_vx_r[pin_idx_r]);
                    pins_vy_r[pin_idx_r] <= decay(pins_vy_r[pin_idx_r]);
`else
                    pins_vx_r[pin_idx_r] <= pins_vx_r[pin_idx_r];
                    pins_vy_r[pin_idx_r] <= pins_vy_r[pin_idx_r];
`endif
                    pin_idx_r <= (pin_idx_r == LAST_PIN) ? 4'd0 : pin_idx_r + 4'd1;
                end
                default: begin
                    wait_cnt_r <= wait_cnt_r;
                end
            endcase
        end
    end

    assign bus.coll_valid_out = coll_valid_r;
    assign bus.busy_out       = busy_r;
    assign bus.step_done_out  = step_done_r;
    assign bus.timeout_out    = timeout_r;
    assign bus.pins_x_out     = pins_x_r;
    assign bus.pins_y_out     = pins_y_r;
    assign bus.pins_vx_out    = pins_vx_r;
    assign bus.pins_vy_out    = pins_vy_r;
    assign bus.pins_hit_out   = pins_hit_r;
endmodule

// File: tb/tb_pin_motion_integrator.sv
// Directed plus randomized bench for pin_motion_integrator against an
// arithmetic reference model of the pin rack physics.
module tb_pin_motion_integrator;
    localparam int PS = 2;
    localparam int FS = 4;

    logic clk;
    logic rst;
    int   nvec;
    int   nerr;

    int   mx[10], my[10], mvx[10], mvy[10];
    logic [9:0] mhit;
    logic mto;
    int   cvx[10], cvy[10];
    int   rack_tx[10] = '{512, 452, 572, 392, 512, 632, 332, 452, 572, 692};
    int   rack_ty[10] = '{300, 404, 404, 508, 508, 508, 612, 612, 612, 612};

    pin_motion_if bus_if ();

    pin_motion_integrator #(.POS_SHIFT(PS), .FRICTION_SHIFT(FS), .TIMEOUT(255)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int floor_shr(input int v, input int s);
        int d;
        d = 1 << s;
        if (v >= 0) return v / d;
        return -((-v + d - 1) / d);
    endfunction

    function automatic int clamp16(input int v);
        if (v < 0) return 0;
        if (v > 65535) return 65535;
        return v;
    endfunction

    function automatic int friction(input int v);
`ifdef PIN_FRICTION_EN
        if (v < (1 << FS) && v > -(1 << FS)) return 0;
        return v - floor_shr(v, FS);
`else
        return v;
`endif
    endfunction

    task automatic model_rack();
        for (int i = 0; i < 10; i++) begin
            mx[i] = rack_tx[i]; my[i] = rack_ty[i]; mvx[i] = 0; mvy[i] = 0;
        end
        mhit = 10'd0;
    endtask

    task automatic model_integ();
        for (int i = 0; i < 10; i++) begin
            mx[i]  = clamp16(mx[i] + floor_shr(mvx[i], PS));
            my[i]  = clamp16(my[i] + floor_shr(mvy[i], PS));
            mvx[i] = friction(mvx[i]);
            mvy[i] = friction(mvy[i]);
        end
    endtask

    task automatic drive_coll(input logic [9:0] hits);
        for (int i = 0; i < 10; i++) begin
            bus_if.coll_vx_in[i] = 16'(cvx[i]);
            bus_if.coll_vy_in[i] = 16'(cvy[i]);
        end
        bus_if.coll_hit_in = hits;
    endtask

    task automatic compare_all(input string tag);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("%s_x%0d", tag, i),  {16'd0, bus_if.pins_x_out[i]},  32'(mx[i]));
            chk($sformatf("%s_y%0d", tag, i),  {16'd0, bus_if.pins_y_out[i]},  32'(my[i]));
            chk($sformatf("%s_vx%0d", tag, i), {16'd0, bus_if.pins_vx_out[i]}, {16'd0, 16'(mvx[i])});
            chk($sformatf("%s_vy%0d", tag, i), {16'd0, bus_if.pins_vy_out[i]}, {16'd0, 16'(mvy[i])});
        end
        chk({tag, "_hit"}, {22'd0, bus_if.pins_hit_out}, {22'd0, mhit});
        chk({tag, "_to"},  {31'd0, bus_if.timeout_out}, {31'd0, mto});
    endtask

    // gap: WAIT cycles before coll_done_in; negative means never (timeout path)
    task automatic run_step(input string tag, input logic [9:0] hits, input int gap);
        int n;
        bus_if.step_in = 1'b1;
        tick();
        bus_if.step_in = 1'b0;
        chk({tag, "_req_valid"}, {31'd0, bus_if.coll_valid_out}, 32'd1);
        chk({tag, "_req_busy"},  {31'd0, bus_if.busy_out}, 32'd1);
        tick();
        chk({tag, "_wait_valid"}, {31'd0, bus_if.coll_valid_out}, 32'd0);
        chk({tag, "_wait_x0"}, {16'd0, bus_if.pins_x_out[0]}, 32'(mx[0]));
        chk({tag, "_wait_y9"}, {16'd0, bus_if.pins_y_out[9]}, 32'(my[9]));
        if (gap >= 0) begin
            for (int g = 0; g < gap; g++) begin
                bus_if.step_in = (g == 0);
                tick();
            end
            bus_if.step_in = 1'b0;
            drive_coll(hits);
            bus_if.coll_done_in = 1'b1;
            tick();
            bus_if.coll_done_in = 1'b0;
            bus_if.coll_hit_in  = 10'h3FF;
            for (int i = 0; i < 10; i++) begin
                if (hits[i]) begin
                    mvx[i] = cvx[i]; mvy[i] = cvy[i]; mhit[i] = 1'b1;
                end
            end
            for (int j = 1; j <= 10; j++) begin
                tick();
                chk($sformatf("%s_done_c%0d", tag, j), {31'd0, bus_if.step_done_out}, {31'd0, (j == 10)});
            end
        end else begin
            drive_coll(hits);
            bus_if.step_in = 1'b1;
            tick();
            bus_if.step_in = 1'b0;
            n = 0;
            while (bus_if.step_done_out !== 1'b1 && n < 600) begin
                tick();
                n++;
            end
            chk({tag, "_to_done"}, {31'd0, bus_if.step_done_out}, 32'd1);
            mto = 1'b1;
        end
        model_integ();
        tick();
        chk({tag, "_idle_busy"}, {31'd0, bus_if.busy_out}, 32'd0);
        chk({tag, "_idle_done"}, {31'd0, bus_if.step_done_out}, 32'd0);
        compare_all(tag);
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        for (int i = 0; i < 10; i++) begin cvx[i] = 0; cvy[i] = 0; end
        rst = 1'b1;
        bus_if.step_in = 1'b1;
        bus_if.rack_in = 1'b1;
        bus_if.coll_done_in = 1'b1;
        drive_coll(10'h3FF);
        tick();
        tick();
        rst = 1'b0;
        bus_if.step_in = 1'b0;
        bus_if.rack_in = 1'b0;
        bus_if.coll_done_in = 1'b0;
        bus_if.coll_hit_in = 10'd0;
        model_rack();
        mto = 1'b0;
        chk("rst_valid", {31'd0, bus_if.coll_valid_out}, 32'd0);
        chk("rst_busy",  {31'd0, bus_if.busy_out}, 32'd0);
        chk("rst_done",  {31'd0, bus_if.step_done_out}, 32'd0);
        compare_all("rst");

        run_step("nohit", 10'd0, 2);

        cvx[0] = 400; cvy[0] = 800;
        run_step("pin0", 10'b0000000001, 0);
        chk("pin0_x_abs", {16'd0, bus_if.pins_x_out[0]}, 32'd612);
        chk("pin0_y_abs", {16'd0, bus_if.pins_y_out[0]}, 32'd500);
        chk("pin0_hit_abs", {31'd0, bus_if.pins_hit_out[0]}, 32'd1);
`ifdef PIN_FRICTION_EN
        chk("pin0_vx_abs", {16'd0, bus_if.pins_vx_out[0]}, 32'd375);
`else
        chk("pin0_vx_abs", {16'd0, bus_if.pins_vx_out[0]}, 32'd400);
`endif

        // collision results outside WAIT are ignored
        drive_coll(10'h3FF);
        bus_if.coll_done_in = 1'b1;
        tick();
        tick();
        bus_if.coll_done_in = 1'b0;
        compare_all("idle_done");

        bus_if.rack_in = 1'b1;
        tick();
        bus_if.rack_in = 1'b0;
        model_rack();
        cvx[0] = -400; cvy[0] = 0; cvx[9] = 32767; cvy[9] = 0;
        run_step("sat0", 10'b1000000001, 1);
        for (int s = 1; s < 12; s++) run_step($sformatf("sat%0d", s), 10'd0, 0);
        chk("sat_low_x0",  {16'd0, bus_if.pins_x_out[0]}, 32'd0);
        chk("sat_high_x9", {16'd0, bus_if.pins_x_out[9]}, 32'd65535);

        for (int i = 0; i < 10; i++) begin
            cvx[i] = int'($urandom_range(0, 4000)) - 2000;
            cvy[i] = int'($urandom_range(0, 4000)) - 2000;
        end
        run_step("tmo", 10'h3FF, -1);
        chk("tmo_flag", {31'd0, bus_if.timeout_out}, 32'd1);

        for (int s = 0; s < 12; s++) begin
            for (int i = 0; i < 10; i++) begin
                if (s % 3 == 2) begin
                    cvx[i] = int'($urandom_range(0, 65535)) - 32768;
                    cvy[i] = int'($urandom_range(0, 65535)) - 32768;
                end else begin
                    cvx[i] = int'($urandom_range(0, 3000)) - 1500;
                    cvy[i] = int'($urandom_range(0, 3000)) - 1500;
                end
            end
            run_step($sformatf("rnd%0d", s), 10'($urandom), int'($urandom_range(0, 4)));
        end

        // rack while integrating pin 5, with a step request in the same cycle
        bus_if.step_in = 1'b1;
        tick();
        bus_if.step_in = 1'b0;
        tick();
        drive_coll(10'd0);
        bus_if.coll_done_in = 1'b1;
        tick();
        bus_if.coll_done_in = 1'b0;
        repeat (5) tick();
        bus_if.rack_in = 1'b1;
        bus_if.step_in = 1'b1;
        tick();
        bus_if.rack_in = 1'b0;
        bus_if.step_in = 1'b0;
        model_rack();
        chk("abort_busy", {31'd0, bus_if.busy_out}, 32'd0);
        chk("abort_done", {31'd0, bus_if.step_done_out}, 32'd0);
        compare_all("abort");
        for (int j = 0; j < 12; j++) begin
            tick();
            chk($sformatf("abort_quiet%0d", j), {30'd0, bus_if.busy_out, bus_if.step_done_out}, 32'd0);
        end

        cvx[3] = 1234; cvy[3] = -777;
        run_step("pre_rst", 10'b0000001000, 1);
        bus_if.step_in = 1'b1;
        tick();
        bus_if.step_in = 1'b0;
        tick();
        drive_coll(10'h3FF);
        bus_if.coll_done_in = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus_if.coll_done_in = 1'b0;
        model_rack();
        mto = 1'b0;
        chk("wrst_valid", {31'd0, bus_if.coll_valid_out}, 32'd0);
        chk("wrst_busy",  {31'd0, bus_if.busy_out}, 32'd0);
        chk("wrst_done",  {31'd0, bus_if.step_done_out}, 32'd0);
        compare_all("wrst");
        tick();
        chk("wrst_busy2", {31'd0, bus_if.busy_out}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
